// File: rtl/nn_layer_if.sv
// rtl/nn_layer_if.sv - layer request, weight/bias ROM, activation and output bus of the sequencer
interface nn_layer_if #(
    parameter int W     = 8,
    parameter int IDX_W = 1,
    parameter int NEU_W = 1,
    parameter int WA_W  = 1
);
    logic                    req;
    logic                    ack_layer;
    logic [IDX_W-1:0]        in_sel;
    logic signed [W-1:0]     in_data;
    logic [WA_W-1:0]         w_addr;
    logic signed [W-1:0]     w_data;
    logic [NEU_W-1:0]        b_addr;
    logic signed [W-1:0]     b_data;
    logic                    act_start;
    logic signed [W-1:0]     act_z;
    logic                    act_done;
    logic signed [W-1:0]     act_a;
    logic                    out_we;
    logic [NEU_W-1:0]        out_idx;
    logic signed [W-1:0]     out_data;

    modport master (
        input  req, in_data, w_data, b_data, act_done, act_a,
        output ack_layer, in_sel, w_addr, b_addr, act_start, act_z, out_we, out_idx, out_data
    );

    modport slave (
        output req, in_data, w_data, b_data, act_done, act_a,
        input  ack_layer, in_sel, w_addr, b_addr, act_start, act_z, out_we, out_idx, out_data
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - one fully-connected layer over a single shared MAC with external activation
module nn_layer_sequencer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int W     = 8,
    parameter int FRAC  = 4,
    parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int NEU_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    parameter int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
    input  logic       clk,
    input  logic       rst,
    nn_layer_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_BIAS  = 3'd3;
    localparam logic [2:0] S_ACT   = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(N_IN - 1);
    localparam logic [NEU_W-1:0] N_LAST = NEU_W'(N_OUT - 1);

    logic [2:0]            state;
    logic [IDX_W-1:0]      i;
    logic [IDX_W-1:0]      in_sel;
    logic [NEU_W-1:0]      n;
    logic [NEU_W-1:0]      b_addr;
    logic [NEU_W-1:0]      out_idx;
    logic [WA_W-1:0]       w_addr;
    logic signed [W-1:0]   acc;
    logic signed [W-1:0]   x_q;
    logic signed [W-1:0]   act_z;
    logic signed [W-1:0]   out_data;
    logic signed [W-1:0]   term;
    logic signed [2*W-1:0] prod;
    logic                  act_start;
    logic                  out_we;

    // ROM latency means w_data lines up with the x_q captured one cycle earlier
    assign prod = {{W{bus.w_data[W-1]}}, bus.w_data} * {{W{x_q[W-1]}}, x_q};
    assign term = W'(prod >>> FRAC);

    assign bus.ack_layer = (state == S_DONE);
    assign bus.in_sel    = in_sel;
    assign bus.w_addr    = w_addr;
    assign bus.b_addr    = b_addr;
    assign bus.act_start = act_start;
    assign bus.act_z     = act_z;
    assign bus.out_we    = out_we;
    assign bus.out_idx   = out_idx;
    assign bus.out_data  = out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            i         <= '0;
            n         <= '0;
            in_sel    <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_idx   <= '0;
            acc       <= '0;
            x_q       <= '0;
            act_z     <= '0;
            out_data  <= '0;
            act_start <= 1'b0;
            out_we    <= 1'b0;
        end else begin
            act_start <= 1'b0;
            out_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        state  <= S_MAC;
                        n      <= '0;
                        i      <= '0;
                        acc    <= '0;
                        in_sel <= '0;
                        w_addr <= '0;
                    end
                end
                S_MAC: begin
                    x_q <= bus.in_data;
                    if (i != '0) begin
                        acc <= acc + term;
                    end
                    if (i == I_LAST) begin
                        state  <= S_DRAIN;
                        b_addr <= n;
                    end else begin
                        i      <= i + IDX_W'(1);
                        in_sel <= i + IDX_W'(1);
                        w_addr <= w_addr + WA_W'(1);
                    end
                end
                S_DRAIN: begin
                    acc   <= acc + term;
                    state <= S_BIAS;
                end
                S_BIAS: begin
                    act_z     <= acc + bus.b_data;
                    act_start <= 1'b1;
                    state     <= S_ACT;
                end
                S_ACT: begin
                    // act_done in the act_start cycle cannot belong to this request
                    if (bus.act_done && !act_start) begin
                        out_data <= bus.act_a;
                        out_idx  <= n;
                        out_we   <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    acc <= '0;
                    i   <= '0;
                    if (n == N_LAST) begin
                        state <= S_DONE;
                    end else begin
                        n      <= n + NEU_W'(1);
                        in_sel <= '0;
                        w_addr <= w_addr + WA_W'(1);
                        state  <= S_MAC;
                    end
                end
                S_DONE: begin
                    if (!bus.req) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - two sequencer configurations against an arithmetic layer model
module tb_nn_layer_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic req;
    int   total = 0;
    int   bad   = 0;

    nn_layer_if #(.W(8), .IDX_W(1), .NEU_W(1), .WA_W(1)) ifa ();
    nn_layer_if #(.W(8), .IDX_W(2), .NEU_W(1), .WA_W(3)) ifb ();

    nn_layer_sequencer #(.N_IN(2), .N_OUT(1), .W(8), .FRAC(4), .IDX_W(1), .NEU_W(1), .WA_W(1))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    nn_layer_sequencer #(.N_IN(3), .N_OUT(2), .W(8), .FRAC(4), .IDX_W(2), .NEU_W(1), .WA_W(3))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    int nin [2] = '{2, 3};
    int nout[2] = '{1, 2};
    int w_m [2][8];
    int x_m [2][4];
    int b_m [2][2];
    int key [2];
    int dly [2];
    int wlog_b[64];

    int q_idx[2][$];
    int q_dat[2][$];
    int q_z  [2][$];

    logic       rd_a, rd_b, sp;
    logic [7:0] ra_a, ra_b, spa;
    logic signed [7:0] za_cap, zb_cap;

    assign ifa.req      = req;
    assign ifb.req      = req;
    assign ifa.in_data  = 8'(x_m[0][ifa.in_sel]);
    assign ifb.in_data  = 8'(x_m[1][ifb.in_sel]);
    assign ifa.act_done = rd_a | sp;
    assign ifb.act_done = rd_b | sp;
    assign ifa.act_a    = rd_a ? ra_a : spa;
    assign ifb.act_a    = rd_b ? ra_b : spa;

    always @(posedge clk) begin
        ifa.w_data <= 8'(w_m[0][ifa.w_addr]);
        ifa.b_data <= 8'(b_m[0][ifa.b_addr]);
        ifb.w_data <= 8'(w_m[1][ifb.w_addr]);
        ifb.b_data <= 8'(b_m[1][ifb.b_addr]);
    end

    always @(negedge clk) begin
        if (ifa.out_we) begin
            q_idx[0].push_back(int'(ifa.out_idx));
            q_dat[0].push_back(int'(ifa.out_data));
        end
        if (ifb.out_we) begin
            q_idx[1].push_back(int'(ifb.out_idx));
            q_dat[1].push_back(int'(ifb.out_data));
        end
        if (ifa.act_start) q_z[0].push_back(int'(ifa.act_z));
        if (ifb.act_start) q_z[1].push_back(int'(ifb.act_z));
    end

    // activation units: result = z xor key, act_done dly cycles after act_start
    initial begin
        rd_a = 1'b0; ra_a = '0;
        forever begin
            @(negedge clk);
            if (ifa.act_start) begin
                za_cap = ifa.act_z;
                repeat (dly[0]) @(negedge clk);
                ra_a = 8'(za_cap) ^ 8'(key[0]);
                rd_a = 1'b1;
                @(negedge clk);
                rd_a = 1'b0;
            end
        end
    end

    initial begin
        rd_b = 1'b0; ra_b = '0;
        forever begin
            @(negedge clk);
            if (ifb.act_start) begin
                zb_cap = ifb.act_z;
                repeat (dly[1]) @(negedge clk);
                ra_b = 8'(zb_cap) ^ 8'(key[1]);
                rd_b = 1'b1;
                @(negedge clk);
                rd_b = 1'b0;
            end
        end
    end

    function automatic int wrap8(int v);
        int r = v & 255;
        return (r > 127) ? r - 256 : r;
    endfunction

    function automatic int model_z(int k, int n);
        int acc = 0;
        for (int i = 0; i < nin[k]; i++)
            acc += wrap8((w_m[k][n * nin[k] + i] * x_m[k][i]) >>> 4);
        return wrap8(acc + b_m[k][n]);
    endfunction

    function automatic int exp_ack(int k);
        return nout[k] * (nin[k] + 4 + dly[k]) + 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_rand(input int k);
        for (int j = 0; j < 8; j++) w_m[k][j] = int'($urandom_range(255)) - 128;
        for (int j = 0; j < 4; j++) x_m[k][j] = int'($urandom_range(255)) - 128;
        for (int j = 0; j < 2; j++) b_m[k][j] = int'($urandom_range(255)) - 128;
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < 2; k++) begin
            string s = $sformatf("%s_%0d", tag, k);
            chk({s, "_nwrites"}, q_idx[k].size(), nout[k]);
            chk({s, "_nacts"}, q_z[k].size(), nout[k]);
            for (int n = 0; n < nout[k]; n++) begin
                if (n < q_idx[k].size()) begin
                    chk($sformatf("%s_idx%0d", s, n), q_idx[k][n], n);
                    chk($sformatf("%s_out%0d", s, n), q_dat[k][n], wrap8(model_z(k, n) ^ key[k]));
                end
                if (n < q_z[k].size())
                    chk($sformatf("%s_z%0d", s, n), q_z[k][n], model_z(k, n));
            end
            q_idx[k].delete();
            q_dat[k].delete();
            q_z[k].delete();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a_ack"},  int'(ifa.ack_layer), 0);
        chk({tag, "_a_acts"}, int'(ifa.act_start), 0);
        chk({tag, "_a_we"},   int'(ifa.out_we), 0);
        chk({tag, "_a_sel"},  int'(ifa.in_sel), 0);
        chk({tag, "_a_wa"},   int'(ifa.w_addr), 0);
        chk({tag, "_a_ba"},   int'(ifa.b_addr), 0);
        chk({tag, "_a_oidx"}, int'(ifa.out_idx), 0);
        chk({tag, "_a_z"},    int'(ifa.act_z), 0);
        chk({tag, "_a_od"},   int'(ifa.out_data), 0);
        chk({tag, "_b_ack"},  int'(ifb.ack_layer), 0);
        chk({tag, "_b_acts"}, int'(ifb.act_start), 0);
        chk({tag, "_b_we"},   int'(ifb.out_we), 0);
        chk({tag, "_b_sel"},  int'(ifb.in_sel), 0);
        chk({tag, "_b_wa"},   int'(ifb.w_addr), 0);
        chk({tag, "_b_ba"},   int'(ifb.b_addr), 0);
        chk({tag, "_b_oidx"}, int'(ifb.out_idx), 0);
        chk({tag, "_b_z"},    int'(ifb.act_z), 0);
        chk({tag, "_b_od"},   int'(ifb.out_data), 0);
    endtask

    // cycle 0 is the cycle in which req is first sampled high
    task automatic run_layer(input int drop_at, input int spur_at,
                             output int ca, output int cb, output int na, output int nb);
        int cyc = 0;
        ca = -1; cb = -1; na = 0; nb = 0;
        @(negedge clk);
        req = 1'b1;
        while ((ca < 0 || cb < 0) && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc < 64) wlog_b[cyc] = int'(ifb.w_addr);
            if (ifa.ack_layer) begin na++; if (ca < 0) ca = cyc; end
            if (ifb.ack_layer) begin nb++; if (cb < 0) cb = cyc; end
            if (cyc == drop_at) req = 1'b0;
            sp  = (cyc == spur_at);
            spa = 8'h3C;
        end
        sp = 1'b0;
    endtask

    task automatic end_layer();
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_scn1();
        w_m[0][0] = -23; w_m[0][1] = 23;
        x_m[0][0] = 16;  x_m[0][1] = 32;
        b_m[0][0] = -9;
        key[0] = 0; dly[0] = 1;
    endtask

    int ca, cb, na, nb;

    initial begin
        rst = 1'b1; req = 1'b0; sp = 1'b0; spa = '0;
        for (int k = 0; k < 2; k++) begin
            load_rand(k);
            key[k] = 0;
            dly[k] = 1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // scenario 1: reference numbers, identity activation
        set_scn1();
        run_layer(-1, -1, ca, cb, na, nb);
        chk("t1_ack_a", ca, 8);
        chk("t1_ack_b", cb, exp_ack(1));
        if (q_z[0].size() > 0) chk("t1_z_a", q_z[0][0], 14);
        if (q_dat[0].size() > 0) chk("t1_out_a", q_dat[0][0], 14);
        check_results("t1");
        end_layer();
        chk("t1_ack_low_a", int'(ifa.ack_layer), 0);

        // scenario 2: accumulator wraps instead of saturating
        w_m[0][0] = 127; w_m[0][1] = 127;
        x_m[0][0] = 127; x_m[0][1] = 127;
        b_m[0][0] = 0;
        load_rand(1);
        run_layer(-1, -1, ca, cb, na, nb);
        if (q_z[0].size() > 0) chk("t2_z_a", q_z[0][0], -32);
        check_results("t2");
        end_layer();

        // scenario 3: 3x2 layer, slow activation
        load_rand(0); load_rand(1);
        dly[1] = 4; key[1] = int'($urandom_range(255));
        run_layer(-1, -1, ca, cb, na, nb);
        chk("t3_ack_b", cb, 23);
        chk("t3_ack_a", ca, exp_ack(0));
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t3_waddr_n0_c%0d", c), wlog_b[1 + c], c);
            chk($sformatf("t3_waddr_n1_c%0d", c), wlog_b[12 + c], 3 + c);
        end
        check_results("t3");
        end_layer();

        // scenario 4: reset while both instances wait in ACT of neuron 0
        dly[0] = 4; dly[1] = 4;
        load_rand(0); load_rand(1);
        @(negedge clk);
        req = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("t4_rst");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_nowe_a", q_idx[0].size(), 0);
        chk("t4_nowe_b", q_idx[1].size(), 0);
        check_idle("t4_after");
        q_z[0].delete(); q_z[1].delete();
        dly[0] = 1; dly[1] = 1;
        run_layer(-1, -1, ca, cb, na, nb);
        chk("t4_ack_a", ca, exp_ack(0));
        chk("t4_ack_b", cb, exp_ack(1));
        check_results("t4");
        end_layer();

        // scenario 5a: req withdrawn during MAC
        load_rand(0); load_rand(1);
        run_layer(1, -1, ca, cb, na, nb);
        chk("t5_ack_a", ca, 8);
        chk("t5_ack_b", cb, exp_ack(1));
        chk("t5_acklen_a", na, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t5_acklen_b", int'(ifb.ack_layer), 0);
        check_results("t5a");

        // scenario 5b: req held after completion
        load_rand(0); load_rand(1);
        run_layer(-1, -1, ca, cb, na, nb);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5_hold_a", int'(ifa.ack_layer), 1);
            chk("t5_hold_b", int'(ifb.ack_layer), 1);
        end
        check_results("t5b");
        end_layer();
        chk("t5_rel_a", int'(ifa.ack_layer), 0);
        chk("t5_rel_b", int'(ifb.ack_layer), 0);

        // scenario 6: stray act_done in IDLE and MAC
        set_scn1();
        load_rand(1);
        @(negedge clk);
        sp = 1'b1; spa = 8'h77;
        @(negedge clk);
        sp = 1'b0;
        run_layer(-1, 1, ca, cb, na, nb);
        chk("t6_ack_a", ca, 8);
        if (q_z[0].size() > 0) chk("t6_z_a", q_z[0][0], 14);
        if (q_dat[0].size() > 0) chk("t6_out_a", q_dat[0][0], 14);
        check_results("t6");
        end_layer();

        // randomized layers
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 2; k++) begin
                load_rand(k);
                key[k] = int'($urandom_range(255));
                dly[k] = int'($urandom_range(1, 3));
            end
            run_layer(-1, -1, ca, cb, na, nb);
            chk($sformatf("rnd%0d_ack_a", r), ca, exp_ack(0));
            chk($sformatf("rnd%0d_ack_b", r), cb, exp_ack(1));
            check_results($sformatf("rnd%0d", r));
            end_layer();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
